intt_gs_butterfly_pipe: RTL

Inverse-NTT radix-2 unit using the Gentleman-Sande butterfly: add/subtract first, then multiply by the twiddle.
- out_0 = (a + b) mod Q
- out_1 = ((a - b) mod Q) * w mod Q
It is the counterpart of the forward multiply-then-butterfly radix-2 unit and consumes coefficient pairs produced by the forward NTT path.
Fully pipelined with a valid/ready handshake, throughput one pair per cycle.

---
 rtl/ntt_pkg.sv | 31 +++
 rtl/barrett_reduce_pipe.sv | 60 ++++++
 rtl/intt_gs_butterfly_pipe.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared NTT constants, latency and modular helper
//
// Purpose: modulus/bus constants shared by the inverse GS butterfly and the
// Barrett reduction pipe, plus the halving helper used by the optional S5.
// Config macro: INTT_HALF_SCALE_EN (adds the x * 2^-1 mod Q output stage).
// Ports: none (package).
package ntt_pkg;

  localparam int WIDTH = 18;
  localparam int Q     = 12289;
  localparam int K     = 14;
  localparam int PW    = 2 * K;                                // product width
  localparam int MU    = int'((64'd1 << PW) / 64'(Q));         // 21843
  localparam int MUW   = $clog2(MU + 1);                       // 15 bits

  localparam logic [WIDTH-1:0] Q_W = WIDTH'(Q);

`ifdef INTT_HALF_SCALE_EN
  localparam int INTT_LAT = 5;
`else
  localparam int INTT_LAT = 4;
`endif

  // x * 2^-1 mod Q for x in [0,Q-1]: odd values get Q added so the shift is exact.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] t;
    t = x[0] ? (x + Q_W) : x;
    return t >> 1;
  endfunction

endpackage

// File: rtl/barrett_reduce_pipe.sv
// rtl/barrett_reduce_pipe.sv - two-stage Barrett reduction of a 2K-bit product mod Q
//
// Purpose: S3 estimates the quotient and forms r = p - qhat*Q (r < 3Q);
// S4 subtracts Q up to twice, registering a result in [0,Q-1].
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_en           advance the pipe (low = hold every register)
//   i_valid/i_p    incoming product and its valid bit
//   o_valid/o_res  reduced result and its valid bit (registered)
module barrett_reduce_pipe
  import ntt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [PW-1:0]    i_p,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_res
);

  localparam int PMW = PW + MUW;

  logic [PMW-1:0]   w_pmu;
  logic [MUW-1:0]   w_qhat;
  logic [PW-1:0]    w_r;
  logic [WIDTH-1:0] w_r1;
  logic [WIDTH-1:0] w_r2;

  logic             r_s3_valid;
  logic [WIDTH-1:0] r_s3_r;
  logic             r_s4_valid;
  logic [WIDTH-1:0] r_s4_res;

  assign w_pmu  = PMW'(i_p) * PMW'(MU);
  assign w_qhat = MUW'(w_pmu >> PW);
  // qhat underestimates by at most 2, so r fits well inside WIDTH bits.
  assign w_r    = i_p - PW'(w_qhat) * PW'(Q);

  assign w_r1 = (r_s3_r >= Q_W) ? (r_s3_r - Q_W) : r_s3_r;
  assign w_r2 = (w_r1 >= Q_W) ? (w_r1 - Q_W) : w_r1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_valid <= 1'b0;
      r_s3_r     <= '0;
      r_s4_valid <= 1'b0;
      r_s4_res   <= '0;
    end else if (i_en) begin
      r_s3_valid <= i_valid;
      r_s3_r     <= WIDTH'(w_r);
      r_s4_valid <= r_s3_valid;
      r_s4_res   <= w_r2;
    end
  end

  assign o_valid = r_s4_valid;
  assign o_res   = r_s4_res;

endmodule

// File: rtl/intt_gs_butterfly_pipe.sv
// rtl/intt_gs_butterfly_pipe.sv - pipelined inverse-NTT Gentleman-Sande butterfly
//
// Purpose: out_0 = (a+b) mod Q, out_1 = ((a-b) mod Q) * w mod Q, one pair per
// cycle, latency INTT_LAT, with a single global stall when the output is held.
// Config macro: INTT_HALF_SCALE_EN adds S5 scaling both outputs by 2^-1 mod Q.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          input handshake
//   in_a, in_b, in_w           coefficients and inverse twiddle, in [0,Q-1]
//   out_valid/out_ready        output handshake
//   out_0, out_1               results, in [0,Q-1]
module intt_gs_butterfly_pipe
  import ntt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_0,
  output logic [WIDTH-1:0] out_1
);

  logic             w_stall;
  logic             w_en;
  logic [WIDTH-1:0] w_sum_raw;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [PW-1:0]    w_p;
  logic             w_s4_valid;
  logic [WIDTH-1:0] w_s4_res;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_sum;
  logic [WIDTH-1:0] r_s1_diff;
  logic [WIDTH-1:0] r_s1_w;
  logic             r_s2_valid;
  logic [PW-1:0]    r_s2_p;
  logic [WIDTH-1:0] r_s2_sum;
  logic [WIDTH-1:0] r_s3_sum;
  logic [WIDTH-1:0] r_s4_sum;

  // Every stage holds while a valid result waits on the output.
  assign w_stall  = out_valid && !out_ready;
  assign w_en     = !w_stall;
  assign in_ready = !w_stall;

  assign w_sum_raw = in_a + in_b;
  assign w_sum     = (w_sum_raw >= Q_W) ? (w_sum_raw - Q_W) : w_sum_raw;
  assign w_diff    = (in_a >= in_b) ? (in_a - in_b) : (in_a + Q_W - in_b);

  // diff, w < Q < 2^K, so the product always fits in 2K bits.
  assign w_p = PW'(r_s1_diff) * PW'(r_s1_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_diff  <= '0;
      r_s1_w     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_p     <= '0;
      r_s2_sum   <= '0;
      r_s3_sum   <= '0;
      r_s4_sum   <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_sum   <= w_sum;
      r_s1_diff  <= w_diff;
      r_s1_w     <= in_w;
      r_s2_valid <= r_s1_valid;
      r_s2_p     <= w_p;
      r_s2_sum   <= r_s1_sum;
      // sum rides alongside the reduction stages to stay aligned with out_1
      r_s3_sum   <= r_s2_sum;
      r_s4_sum   <= r_s3_sum;
    end
  end

  barrett_reduce_pipe u_barrett (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_en),
    .i_valid (r_s2_valid),
    .i_p     (r_s2_p),
    .o_valid (w_s4_valid),
    .o_res   (w_s4_res)
  );

`ifdef INTT_HALF_SCALE_EN
  logic             r_s5_valid;
  logic [WIDTH-1:0] r_s5_out0;
  logic [WIDTH-1:0] r_s5_out1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s5_valid <= 1'b0;
      r_s5_out0  <= '0;
      r_s5_out1  <= '0;
    end else if (w_en) begin
      r_s5_valid <= w_s4_valid;
      r_s5_out0  <= half_mod(r_s4_sum);
      r_s5_out1  <= half_mod(w_s4_res);
    end
  end

  assign out_valid = r_s5_valid;
  assign out_0     = r_s5_out0;
  assign out_1     = r_s5_out1;
`else
  assign out_valid = w_s4_valid;
  assign out_0     = r_s4_sum;
  assign out_1     = w_s4_res;
`endif

endmodule
